// File: rtl/alu_ctrl.sv
// alu_ctrl: command front-end and result FIFO for the combinational alu.
// Registers operands onto the ALU, captures the result one cycle later.
module alu_ctrl #(
    parameter int LEN_A = 4,
    parameter int LEN_B = 5,
    parameter int LEN_F = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN_A-1:0] in_a,
    input  logic [LEN_B-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_chain,
    output logic [LEN_A-1:0] alu_a,
    output logic [LEN_B-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [LEN_F-1:0] alu_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_F-1:0] out_f,
    output logic             out_err,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t state, state_nx;

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [LEN_F-1:0] last_f;
    logic [LEN_F:0]   mem [DEPTH];

    logic             accept, push, pop, err;
    logic [LEN_F-1:0] cap_f;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    assign err    = (alu_op == 3'b000);
    // Undefined opcodes leave the ALU output undefined; never store it
    assign cap_f  = err ? '0 : alu_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = EXEC;
            EXEC: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        push     = 1'b0;
        unique case (state)
            IDLE: in_ready = (count < FULL);
            EXEC: begin
                busy = 1'b1;
                push = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else if (accept) begin
            alu_a  <= in_chain ? last_f[LEN_A-1:0] : in_a;
            alu_b  <= in_b;
            alu_op <= in_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          last_f <= '0;
        else if (push && !err) last_f <= alu_f;
    end

    // Accept reserves a slot, so the capture push never overflows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {err, cap_f};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_valid = (count != '0);
    assign out_f     = mem[rd_ptr][LEN_F-1:0];
    assign out_err   = mem[rd_ptr][LEN_F];

endmodule
